// File: rtl/stream_source_v1.sv
// stream_source_v1: Avalon-ST source for the DE2 display-sink stream.
// Words come from the board switches on a debounced KEY press, or from a
// periodic auto-increment generator. They queue in a small circular FIFO
// whose head is presented with readyLatency-0 handshaking.
module stream_source_v1 #(
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_PERIOD     = 50000000
) (
  input  logic                   clk_hifreq,
  input  logic                   rst,
  input  logic [17:0]            switches,
  input  logic [3:0]             buttons,
  output logic [31:0]            data_out,
  output logic                   valid,
  input  logic                   ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [7:0]             leds_green
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ATW = $clog2(AUTO_PERIOD + 1);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ATW-1:0] AT_LAST  = ATW'(AUTO_PERIOD - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  // Button path: p0/p1 synchronizer, p2 debounced level and press pulse
  logic [3:0]     btn_sync_p0, btn_sync_p1;
  logic [3:0]     btn_deb_p2, press_p2;
  logic [DBW-1:0] db_cnt [4];

  // Push/pop control
  logic        flush, man_push, toggle, pop, full;
  logic        push_req, push_ok, push_drop, auto_take;
  logic [31:0] push_word;

  // Word sources
  logic [7:0]     seq;
  logic [15:0]    auto_cnt;
  logic           auto_mode, auto_pending;
  logic [ATW-1:0] auto_timer;

  // FIFO storage and next-state
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_n, rd_n;
  logic [CW-1:0] count_n;
  logic [31:0]   data_n;

  // KEY0 has no function; its press pulse is intentionally left unconsumed.
  logic unused_press;
  assign unused_press = press_p2[0];

  // Synchronize the active-low keys and accept a new level only after it has
  // been stable for DEBOUNCE_CYCLES; a press is the debounced 1->0 edge.
  always_ff @(posedge clk_hifreq) begin
    if (rst) begin
      btn_sync_p0 <= '1;
      btn_sync_p1 <= '1;
      btn_deb_p2  <= '1;
      press_p2    <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      btn_sync_p0 <= buttons;
      btn_sync_p1 <= btn_sync_p0;
      press_p2    <= '0;
      for (int i = 0; i < 4; i++) begin
        if (btn_sync_p1[i] == btn_deb_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]     <= '0;
          btn_deb_p2[i] <= btn_sync_p1[i];
          press_p2[i]   <= btn_deb_p2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // Arbitrate flush > manual > auto and decide whether the push fits.
  always_comb begin
    flush     = press_p2[3];
    man_push  = press_p2[1];
    toggle    = press_p2[2];
    pop       = valid & ready;
    full      = (fifo_count == FULL_CNT);
    push_req  = man_push | auto_pending;
    push_word = man_push ? {6'b0, seq, switches} : {6'b0, seq, 2'b0, auto_cnt};
    push_ok   = push_req & ~flush & (~full | pop);
    push_drop = push_req & ~flush & full & ~pop;
    auto_take = auto_pending & ~man_push;
  end

  // Next FIFO state; the new head bypasses memory when it is written this cycle.
  always_comb begin
    wr_n    = wr_ptr;
    rd_n    = rd_ptr;
    count_n = fifo_count;
    data_n  = '0;
    if (flush) begin
      wr_n    = '0;
      rd_n    = '0;
      count_n = '0;
    end else begin
      if (push_ok) wr_n = wr_ptr + PW'(1);
      if (pop)     rd_n = rd_ptr + PW'(1);
      if (push_ok && !pop)      count_n = fifo_count + CW'(1);
      else if (!push_ok && pop) count_n = fifo_count - CW'(1);
    end
    if (count_n != '0) data_n = (push_ok && (wr_ptr == rd_n)) ? push_word : mem[rd_n];
  end

  // FIFO storage write.
  always_ff @(posedge clk_hifreq) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  // Pointers, occupancy and the registered stream outputs.
  always_ff @(posedge clk_hifreq) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      valid      <= 1'b0;
      data_out   <= '0;
    end else begin
      wr_ptr     <= wr_n;
      rd_ptr     <= rd_n;
      fifo_count <= count_n;
      valid      <= (count_n != '0);
      data_out   <= data_n;
    end
  end

  // Sequence number, auto word counter and sticky overflow flag.
  always_ff @(posedge clk_hifreq) begin
    if (rst) begin
      seq      <= '0;
      auto_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)              seq      <= seq + 8'd1;
      if (push_ok && !man_push) auto_cnt <= auto_cnt + 16'd1;
      if (flush)                overflow <= 1'b0;
      else if (push_drop)       overflow <= 1'b1;
    end
  end

  // Auto mode: periodic timer raises a pending request that waits for a free slot.
  always_ff @(posedge clk_hifreq) begin
    if (rst) begin
      auto_mode    <= 1'b0;
      auto_timer   <= '0;
      auto_pending <= 1'b0;
    end else begin
      if (toggle) auto_mode <= ~auto_mode;
      if (toggle && !auto_mode)
        auto_timer <= '0;
      else if (auto_mode)
        auto_timer <= (auto_timer == AT_LAST) ? '0 : auto_timer + ATW'(1);
      if (toggle && auto_mode)
        auto_pending <= 1'b0;
      else if (auto_mode && (auto_timer == AT_LAST))
        auto_pending <= 1'b1;
      else if (auto_take)
        auto_pending <= 1'b0;
    end
  end

  // Status LEDs.
  always_comb begin
    leds_green = {full, valid, overflow, auto_mode, 4'(fifo_count)};
  end

endmodule

// File: tb/tb_stream_source_v1.sv
// Directed bench for stream_source_v1: expected words are queued as stimulus
// is issued and a separate monitor checks each transfer against the queue.
module tb_stream_source_v1;

  logic        clk_hifreq = 1'b0;
  logic        rst        = 1'b1;
  logic [17:0] switches   = '0;
  logic [3:0]  buttons    = 4'hF;
  logic        ready      = 1'b1;
  logic [31:0] data_out;
  logic        valid;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [7:0]  leds_green;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          cyc    = 0;
  logic [31:0] exp_q[$];
  int          xfer_cyc[$];
  logic        chk_stall = 1'b0;
  logic [7:0]  exp_seq   = 8'd0;

  stream_source_v1 #(.DEPTH(8), .DEBOUNCE_CYCLES(4), .AUTO_PERIOD(16)) dut (
    .clk_hifreq(clk_hifreq),
    .rst(rst),
    .switches(switches),
    .buttons(buttons),
    .data_out(data_out),
    .valid(valid),
    .ready(ready),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .leds_green(leds_green)
  );

  always #10 clk_hifreq = ~clk_hifreq;
  always @(posedge clk_hifreq) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_man(input logic [7:0] s, input logic [17:0] sw);
    return {6'b0, s, sw};
  endfunction

  function automatic logic [31:0] mk_auto(input logic [7:0] s, input logic [15:0] a);
    return {6'b0, s, 2'b0, a};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_hifreq);
    #1;
  endtask

  task automatic press(input int b);
    buttons[b] = 1'b0;
    tick(10);
    buttons[b] = 1'b1;
    tick(10);
  endtask

  task automatic exp_man(input logic [17:0] sw);
    exp_q.push_back(mk_man(exp_seq, sw));
    exp_seq++;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      tick(1);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compare every transfer with the scoreboard; check stall stability.
  initial begin : monitor
    logic        pv, pr;
    logic [31:0] pd, e;
    pv = 1'b0; pr = 1'b0; pd = '0; e = '0;
    forever begin
      @(negedge clk_hifreq);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (chk_stall && pv && !pr) begin
          check("stall_valid", 32'(valid), 32'd1);
          check("stall_data", data_out, pd);
        end
        if (valid && ready) begin
          xfer_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_xfer: got %h, expected no transfer", data_out);
          end else begin
            e = exp_q.pop_front();
            check("xfer_data", data_out, e);
          end
        end
        pv = valid; pr = ready; pd = data_out;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    // Reset and idle
    rst = 1'b1; ready = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_leds", 32'(leds_green), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", data_out, 32'd0);
    tick(100);
    check("idle_count", 32'(fifo_count), 32'd0);
    check("idle_valid", 32'(valid), 32'd0);

    // Bounced manual press, then a clean one
    xfer_cyc.delete();
    switches = 18'h2A5A5;
    exp_q.push_back(32'h0002A5A5);
    exp_seq = 8'd1;
    for (int i = 0; i < 3; i++) begin
      buttons[1] = 1'b0; tick(1);
      buttons[1] = 1'b1; tick(1);
    end
    buttons[1] = 1'b0; tick(10);
    buttons[1] = 1'b1; tick(10);
    drain(50);
    exp_q.push_back(32'h0006A5A5);
    exp_seq = 8'd2;
    press(1);
    drain(50);
    check("two_xfers", 32'(xfer_cyc.size()), 32'd2);

    // Fill while stalled, overflow on the ninth, drain in order, flush
    rst = 1'b1; tick(1); rst = 1'b0;
    exp_q.delete(); exp_seq = 8'd0;
    ready = 1'b0; chk_stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      switches = 18'h100 + 18'(i);
      if (i < 8) exp_man(switches);
      press(1);
    end
    check("full_count", 32'(fifo_count), 32'd8);
    check("full_ovf", 32'(overflow), 32'd1);
    check("full_leds", 32'(leds_green), 32'hE8);
    check("full_head", data_out, 32'h00000100);
    chk_stall = 1'b0; ready = 1'b1;
    drain(40);
    check("drained_count", 32'(fifo_count), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    press(3);
    check("flush_ovf", 32'(overflow), 32'd0);
    check("flush_leds", 32'(leds_green), 32'd0);
    switches = 18'h3FFFF;
    exp_q.push_back(32'h0023FFFF);
    exp_seq = 8'd9;
    press(1);
    drain(50);

    // Full FIFO: push lands on the same edge as a pop
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      switches = 18'h200 + 18'(i);
      exp_man(switches);
      press(1);
    end
    check("refill_count", 32'(fifo_count), 32'd8);
    switches = 18'h2FF;
    exp_man(switches);
    buttons[1] = 1'b0;
    tick(6);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    buttons[1] = 1'b1;
    check("pushpop_count", 32'(fifo_count), 32'd8);
    check("pushpop_ovf", 32'(overflow), 32'd0);
    tick(10);
    ready = 1'b1;
    drain(40);

    // Auto mode, then a manual press colliding with an auto request
    xfer_cyc.delete();
    switches = 18'h01234;
    exp_q.push_back(mk_auto(exp_seq, 16'd0));
    exp_q.push_back(mk_auto(exp_seq + 8'd1, 16'd1));
    exp_q.push_back(mk_auto(exp_seq + 8'd2, 16'd2));
    exp_seq = exp_seq + 8'd3;
    press(2);
    n = 0;
    while (xfer_cyc.size() < 3 && n < 100) begin
      tick(1);
      n++;
    end
    check("auto_three", 32'(xfer_cyc.size()), 32'd3);
    exp_q.push_back(mk_man(exp_seq, switches));
    exp_q.push_back(mk_auto(exp_seq + 8'd1, 16'd3));
    exp_seq = exp_seq + 8'd2;
    tick(8);
    buttons[1] = 1'b0;
    tick(7);
    buttons[1] = 1'b1;
    buttons[2] = 1'b0;
    tick(10);
    buttons[2] = 1'b1;
    tick(10);
    drain(40);
    tick(40);
    check("auto_off_led", 32'(leds_green[4]), 32'd0);
    check("auto_xfers", 32'(xfer_cyc.size()), 32'd5);
    if (xfer_cyc.size() >= 5) begin
      check("auto_period01", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd16);
      check("auto_period12", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd16);
      check("collide_man", 32'(xfer_cyc[3] - xfer_cyc[2]), 32'd16);
      check("collide_auto", 32'(xfer_cyc[4] - xfer_cyc[3]), 32'd1);
    end

    // Reset while words are queued and stalled
    ready = 1'b0;
    switches = 18'h00055;
    for (int i = 0; i < 5; i++) begin
      exp_man(switches);
      press(1);
    end
    check("q5_count", 32'(fifo_count), 32'd5);
    press(2);
    check("q5_leds", 32'(leds_green), 32'h55);
    rst = 1'b1; tick(1); rst = 1'b0;
    exp_q.delete(); exp_seq = 8'd0;
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_leds", 32'(leds_green), 32'd0);
    check("mid_rst_data", data_out, 32'd0);
    ready = 1'b1;
    tick(30);
    switches = 18'h0ABCD;
    exp_q.push_back(32'h0000ABCD);
    press(1);
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/stream_source_v1.md
Name: stream_source_v1

Overview:
- Avalon-ST source (transmitter) for the 32-bit data/valid/ready stream consumed by the display sink on the DE2 test board.
- Builds words from board switches on debounced button presses, or from an auto-increment generator.
- Buffers the words in a small FIFO and presents them with readyLatency-0 handshaking.
- Sits between the board peripherals and the display sink's data_in/valid/ready.

Parameters:
- DEPTH, 8: FIFO depth in words; power of two, 2..8.
- DEBOUNCE_CYCLES, 500000: cycles a synchronized button level must stay stable before it is accepted (10 ms at 50 MHz).
- AUTO_PERIOD, 50000000: cycles between auto-generated words (1 s at 50 MHz).

Ports:
- clk_hifreq  in  1  system clock, 50 MHz
- rst  in  1  reset
- switches  in  18  word payload source
- buttons  in  4  DE2 KEY[3:0], active-low, asynchronous
- data_out  out  32  stream data, FIFO head
- valid  out  1  stream valid
- ready  in  1  stream ready from sink
- fifo_count  out  $clog2(DEPTH)+1  words held
- overflow  out  1  sticky: a word was dropped
- leds_green  out  8  status

Behaviour:
- Clock and reset: one clock, clk_hifreq. rst is synchronous and active-high. All state is cleared on a rst-high clock edge.
- Reset values: data_out=0, valid=0, fifo_count=0, overflow=0, leds_green=0, FIFO empty, seq=0, auto_cnt=0, auto mode off, auto timer=0, auto_pending=0, all debouncers in the released state.
- Reset mid-operation: a word presented but not yet accepted is discarded without being transferred.
- Button input path, per button:
  - 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles at the new synchronized level; any bounce restarts the count.
  - A press event is a one-cycle pulse on the debounced high-to-low transition. Release produces no event.
- Button functions:
  - buttons[0]: unused; no event is acted on.
  - buttons[1] press: manual push of {6'b0, seq[7:0], switches[17:0]}.
  - buttons[2] press: toggle auto mode. Entering auto mode clears the auto timer.
  - buttons[3] press: flush. FIFO is emptied, overflow is cleared, seq is unchanged.
- Auto mode:
  - The timer counts 0..AUTO_PERIOD-1. At terminal count it sets auto_pending.
  - auto_pending issues a push of {6'b0, seq[7:0], 2'b0, auto_cnt[15:0]} on the first cycle with no manual push, then clears.
  - auto_cnt increments (mod 2^16) only when that push is accepted.
  - Leaving auto mode clears auto_pending.
- Push priority within one cycle: flush > manual > auto. A push coinciding with a flush is discarded, is not counted as overflow, and does not advance seq.
- Push acceptance:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - On acceptance seq increments (mod 256).
  - Otherwise the word is dropped, seq does not increment, and overflow is set. Overflow stays set until flush or rst.
- Stream output:
  - valid = FIFO not empty; data_out = FIFO head; both are registered.
  - Transfer (pop) happens on a clock edge with valid && ready.
  - While valid && !ready, data_out and valid hold stable.
  - A push into an empty FIFO raises valid on the next cycle (latency 1).
  - No combinational path from ready to valid.
  - Back-to-back transfers: one word per cycle while ready stays high.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo DEPTH.
  - fifo_count: +1 on accepted push without pop, −1 on pop without push, unchanged on both.
  - Full means fifo_count==DEPTH.
- leds_green mapping:
  - [3:0] fifo_count
  - [4] auto mode
  - [5] overflow
  - [6] valid
  - [7] full

Test Plan (sim with DEBOUNCE_CYCLES=4, AUTO_PERIOD=16, DEPTH=8):
- Reset then idle, ready=1 -> valid=0, fifo_count=0, leds_green=0; no button events for 100 cycles.
- switches=18'h2A5A5, bounce buttons[1] low/high 3 cycles then hold low 10 cycles, ready=1 -> exactly one transfer, data_out=32'h0002A5A5 (seq 0); the next press transfers seq 1 = 32'h0006A5A5.
- ready=0, 9 manual presses -> fifo_count=8, full LED=1, 9th dropped, overflow=1, seq=8; ready=1 -> 8 words with seq 0..7 in order, valid stable while stalled; buttons[3] press -> overflow=0.
- FIFO full with ready=1, manual push lands on a pop cycle -> push accepted, fifo_count stays 8, overflow stays 0.
- buttons[2] press, ready=1 -> a word every 16 cycles with auto_cnt 0,1,2…; a manual push on the auto terminal cycle -> manual word first, auto word the following cycle, no loss.
- rst asserted for 1 cycle while valid=1, ready=0 with 5 words queued -> next cycle valid=0, fifo_count=0, auto off, seq restarts at 0.
